// File: rtl/input_cond_pkg.sv
// Shared types and width helpers for the input conditioner.
// The hold FSM encoding lives here so every channel agrees on it.
package input_cond_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMING = 2'd1,
        HELD   = 2'd2
    } hold_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold any value 0..max_count, never less than one.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

    function automatic int debounce_width(input int debounce_cycles);
        return cnt_width(debounce_cycles);
    endfunction

    function automatic int hold_width(input int hold_cycles, input int repeat_cycles);
        return cnt_width(max_int(hold_cycles, repeat_cycles));
    endfunction

endpackage

// File: rtl/input_cond_channel.sv
// One conditioned input: synchroniser, debounce filter, edge pulses and
// long-press / auto-repeat detection, all registered on clk.
module input_cond_channel
    import input_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 1000,
    parameter int REPEAT_CYCLES   = 0,
    parameter bit RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic signal,
    output logic stable,
    output logic is_rising,
    output logic is_falling,
    output logic is_held
);

    localparam int DB_W   = debounce_width(DEBOUNCE_CYCLES);
    localparam int HOLD_W = hold_width(HOLD_CYCLES, REPEAT_CYCLES);

    localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [DB_W-1:0]        db_cnt;
    logic [DB_W-1:0]        db_cnt_next;
    logic                   accept;
    logic                   rise_now;
    logic                   fall_now;
    hold_state_t            state;
    logic [HOLD_W-1:0]      hold_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], signal};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // A new level is accepted on the DEBOUNCE_CYCLES-th consecutive differing sample.
    always_comb begin
        accept      = 1'b0;
        db_cnt_next = '0;
        if (synced != stable) begin
            if (db_cnt == DB_LAST) begin
                accept = 1'b1;
            end else begin
                db_cnt_next = db_cnt + DB_W'(1);
            end
        end
    end

    assign rise_now = accept & synced;
    assign fall_now = accept & ~synced;

    always_ff @(posedge clk) begin
        if (rst) begin
            stable     <= RESET_LEVEL;
            db_cnt     <= '0;
            is_rising  <= 1'b0;
            is_falling <= 1'b0;
        end else begin
            db_cnt     <= db_cnt_next;
            is_rising  <= rise_now;
            is_falling <= fall_now;
            if (accept) begin
                stable <= synced;
            end
        end
    end

    // Hold FSM reacts to the same-edge accept so a fall always beats a terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            is_held  <= 1'b0;
        end else begin
            is_held <= 1'b0;
            if (fall_now) begin
                state    <= IDLE;
                hold_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        hold_cnt <= '0;
                        if (rise_now) begin
                            state <= ARMING;
                        end
                    end
                    ARMING: begin
                        if (!stable) begin
                            state    <= IDLE;
                            hold_cnt <= '0;
                        end else if (hold_cnt == HOLD_LAST) begin
                            is_held  <= 1'b1;
                            state    <= HELD;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                    HELD: begin
                        if (!stable) begin
                            state    <= IDLE;
                            hold_cnt <= '0;
                        end else if (REPEAT_CYCLES != 0) begin
                            if (hold_cnt == REPEAT_LAST) begin
                                is_held  <= 1'b1;
                                hold_cnt <= '0;
                            end else begin
                                hold_cnt <= hold_cnt + HOLD_W'(1);
                            end
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        hold_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel button / limit-switch conditioner: CHANNELS independent
// copies of input_cond_channel with their outputs packed bit-per-channel.
module input_conditioner #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 1000,
    parameter int REPEAT_CYCLES   = 0,
    parameter bit RESET_LEVEL     = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] signal,
    output logic [CHANNELS-1:0] stable,
    output logic [CHANNELS-1:0] is_rising,
    output logic [CHANNELS-1:0] is_falling,
    output logic [CHANNELS-1:0] is_held
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        input_cond_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES),
            .RESET_LEVEL    (RESET_LEVEL)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .signal    (signal[i]),
            .stable    (stable[i]),
            .is_rising (is_rising[i]),
            .is_falling(is_falling[i]),
            .is_held   (is_held[i])
        );
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench: a history-window reference model predicts every cycle's
// outputs for a no-repeat and a repeat instance driven by the same inputs.
module tb_input_conditioner;

    localparam int   CH   = 4;
    localparam int   SS   = 2;
    localparam int   DB   = 4;
    localparam int   HC   = 10;
    localparam int   RC   = 5;
    localparam logic RL   = 1'b0;
    localparam int   MAXC = 8000;

    logic          clk;
    logic          rst;
    logic [CH-1:0] signal;
    logic [CH-1:0] stable_a, rising_a, falling_a, held_a;
    logic [CH-1:0] stable_b, rising_b, falling_b, held_b;

    typedef struct packed {
        logic [31:0]   cyc;
        logic [CH-1:0] stable;
        logic [CH-1:0] rising;
        logic [CH-1:0] falling;
        logic [CH-1:0] held_a;
        logic [CH-1:0] held_b;
    } exp_t;

    exp_t exp_q[$];

    int vectors     = 0;
    int miscompares = 0;

    input_conditioner #(
        .CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES(HC), .REPEAT_CYCLES(0), .RESET_LEVEL(RL)
    ) dut_a (
        .clk(clk), .rst(rst), .signal(signal),
        .stable(stable_a), .is_rising(rising_a), .is_falling(falling_a), .is_held(held_a)
    );

    input_conditioner #(
        .CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES(HC), .REPEAT_CYCLES(RC), .RESET_LEVEL(RL)
    ) dut_b (
        .clk(clk), .rst(rst), .signal(signal),
        .stable(stable_b), .is_rising(rising_b), .is_falling(falling_b), .is_held(held_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state: raw input history indexed by edge number.
    int            t = -1;
    int            last_reset = -1;
    int            last_toggle [CH];
    int            rise_edge [CH];
    int            d;
    logic [CH-1:0] stable_m;
    logic [CH-1:0] samp_hist [0:MAXC-1];

    // Level seen at the end of the synchroniser at edge j (RESET_LEVEL until flushed).
    function automatic logic synced_at(input int j, input int ch);
        if (j - SS > last_reset && j - SS >= 0)
            return samp_hist[j - SS][ch];
        return RL;
    endfunction

    // New level accepted when the last DB samples since the last change all differ.
    function automatic logic accepts(input int ch);
        for (int k = 0; k < DB; k++) begin
            if (t - k <= last_reset || t - k <= last_toggle[ch]) return 1'b0;
            if (synced_at(t - k, ch) == stable_m[ch]) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk) begin : model
        exp_t e;
        t = t + 1;
        if (t < MAXC) samp_hist[t] = signal;
        e = '0;
        e.cyc = t;
        if (rst) begin
            last_reset = t;
            stable_m   = {CH{RL}};
            for (int i = 0; i < CH; i++) begin
                rise_edge[i]   = -1;
                last_toggle[i] = -1;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (accepts(i)) begin
                    stable_m[i]    = ~stable_m[i];
                    last_toggle[i] = t;
                    e.rising[i]    = stable_m[i];
                    e.falling[i]   = ~stable_m[i];
                    rise_edge[i]   = stable_m[i] ? t : -1;
                end
                if (stable_m[i] && rise_edge[i] >= 0) begin
                    d = t - rise_edge[i];
                    e.held_a[i] = (d == HC);
                    e.held_b[i] = (d == HC) || (d > HC && ((d - HC) % RC) == 0);
                end
            end
        end
        e.stable = stable_m;
        exp_q.push_back(e);
    end

    task automatic checkOutput(input string name, input logic [CH-1:0] got,
                               input logic [CH-1:0] want, input int cyc);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s at edge %0d: got %b expected %b", name, cyc, got, want);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
        end else begin
            e = exp_q.pop_front();
            checkOutput("stable_a",  stable_a,  e.stable,  e.cyc);
            checkOutput("rising_a",  rising_a,  e.rising,  e.cyc);
            checkOutput("falling_a", falling_a, e.falling, e.cyc);
            checkOutput("held_a",    held_a,    e.held_a,  e.cyc);
            checkOutput("stable_b",  stable_b,  e.stable,  e.cyc);
            checkOutput("rising_b",  rising_b,  e.rising,  e.cyc);
            checkOutput("falling_b", falling_b, e.falling, e.cyc);
            checkOutput("held_b",    held_b,    e.held_b,  e.cyc);
        end
    end

    task automatic applyStimulus(input logic [CH-1:0] value, input logic reset_val, input int cycles);
        signal = value;
        rst    = reset_val;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        rst    = 1'b1;
        signal = 4'hF;
        applyStimulus(4'hF, 1'b1, 3);
        applyStimulus(4'hF, 1'b0, 12);
        applyStimulus(4'h0, 1'b0, 12);
        // Glitch of 3 samples, then exactly 4, then a release.
        applyStimulus(4'h1, 1'b0, 3);
        applyStimulus(4'h0, 1'b0, 10);
        applyStimulus(4'h1, 1'b0, 4);
        applyStimulus(4'h0, 1'b0, 1);
        applyStimulus(4'h0, 1'b0, 12);
        applyStimulus(4'h1, 1'b0, 10);
        applyStimulus(4'h0, 1'b0, 12);
        // Long press on channel 1, then a short press released just after the first held pulse.
        applyStimulus(4'h2, 1'b0, 50);
        applyStimulus(4'h0, 1'b0, 15);
        applyStimulus(4'h2, 1'b0, 17);
        applyStimulus(4'h0, 1'b0, 15);
        // Reset lands seven cycles after the rise on channel 2, input kept high.
        applyStimulus(4'h4, 1'b0, 12);
        applyStimulus(4'h4, 1'b1, 2);
        applyStimulus(4'h4, 1'b0, 30);
        applyStimulus(4'h0, 1'b0, 12);
        for (int n = 0; n < 120; n++) begin
            if ($urandom_range(0, 59) == 0)
                applyStimulus(4'($urandom), 1'b1, 2);
            else
                applyStimulus(4'($urandom), 1'b0, $urandom_range(1, 30));
        end
        applyStimulus(4'h0, 1'b0, 20);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
